alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter that shares a single `alu` instance between two requesters, e.g. the EX stage and an address/branch-target helper. Each requester presents operands and an opcode with a valid/ready handshake. The winner's operation is evaluated combinationally by the embedded `alu` and captured into a one-entry output register. The result is returned on a shared response channel, tagged with the requester ID and subject to backpressure.

## Interface
Parameters:
- `DATA_W`, default 32: operand/result width. Only 32 is supported, since the ALU is fixed at 32 bits.
- `OP_W`, default 4: opcode width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  32  operands
- `req0_op`  in  4  ALU opcode
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1
- `resp_valid`  out  1  result register holds a result
- `resp_ready`  in  1  consumer takes result this cycle
- `resp_id`  out  1  requester that issued the held result
- `resp_result`  out  32  ALU result
- `resp_err`  out  1  opcode was outside 0..9; `resp_result` is 0

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9. All other values are illegal.
- Shifts use `b[4:0]`. SLT and SLTU return 0 or 1. Add and subtract wrap modulo 2^32.
- `out_free` = `!resp_valid || resp_ready`.
- Grant (combinational):
  - Only one requester valid: it wins.
  - Both valid: the one not in `last_grant` wins.
  - Neither valid: no grant.
- `reqN_ready` = grant_N && `out_free`. At most one ready is high per cycle.
- Acceptance: reqN_valid && reqN_ready. On the next edge:
  - result register loads the ALU output, ID N, and err = (op > 9);
  - `resp_valid` goes to 1;
  - `last_grant` goes to N.
- Response: on resp_valid && resp_ready with no new acceptance, `resp_valid` goes to 0. With a simultaneous acceptance, the register reloads and `resp_valid` stays 1.
- Hold: while resp_valid && !resp_ready, the register, `resp_id` and `resp_err` are stable, and both readies are 0.
- State summary, two states:
  - EMPTY (`resp_valid`=0) goes to FULL on acceptance.
  - FULL goes to EMPTY on response without acceptance.
  - FULL stays FULL on response with acceptance, or on stall.
- Requesters must hold valid and operands stable until ready, and must not derive valid from ready.

## Timing
- Reset values: `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_err`=0, `last_grant`=1 (so requester 0 wins the first tie). `req0_ready` and `req1_ready` follow the grant logic.
- Latency: request accepted at edge N, result visible from N+1 through `resp_valid`.
- Throughput: one operation per cycle when `resp_ready` is held 1.
- Combinational paths:
  - `reqN_ready` depends on both valids, `last_grant`, `resp_valid` and `resp_ready`.
  - There is no path from the request inputs to the `resp_*` outputs.
- Reset mid-operation: a held result is discarded immediately (asynchronous), and `last_grant` returns to 1. No transaction completes across reset.
- Starvation bound: a continuously valid requester is accepted within 2 acceptances.

## Structure
- Shared package `alu_pkg`: opcode constants ADD..SRA, `ALU_OP_W`=4, `ALU_DATA_W`=32, and `ALU_OP_MAX`=9, used for the error check. The datapath and decode logic import the package rather than duplicating literals.
- One sub-module: the existing `alu`, instantiated once. Its inputs are muxed from the granted requester.
- Grant mux, output register, and `last_grant` flop all live in `alu_arbiter`.

## Test plan
- Single request, no contention: req0 ADD a=5, b=7 with resp_ready=1. `req0_ready`=1 in cycle 0; cycle 1 shows resp_valid=1, id=0, result=12, err=0.
- Tie round-robin: both valid every cycle, resp_ready=1, req0 SUB 10-3, req1 SRA 0x80000000 by 4. Grants alternate 0,1,0,1. Results are 7 (id 0) and 0xF8000000 (id 1).
- Backpressure: resp_ready=0 for 3 cycles after the first acceptance. Both readies stay 0 and resp_result holds. On resp_ready=1 the next request is accepted the same cycle, with no bubble.
- Illegal opcode: req1 op=12, a=3, b=4. Response has id=1, err=1, result=0.
- Edge ops: SLT 0xFFFFFFFF vs 1 gives 1; SLTU on the same operands gives 0; SLL 1 by b=33 gives 2, since only `b[4:0]` is used; ADD 0xFFFFFFFF+1 gives 0.
- Async reset while FULL and stalled: resp_valid drops without a clock edge. After release, a tie grants req0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings, and the arbiter's
// output-register state type.
package alu_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int ALU_DATA_W = 32;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'd9;

    // Highest legal opcode; anything above it is flagged as an error.
    localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = OP_SRA;

    // Occupancy of the one-entry result register.
    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Illegal opcodes produce a zero result and
// raise err.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] a,
    input  logic [ALU_DATA_W-1:0] b,
    input  logic [ALU_OP_W-1:0]   op,
    output logic [ALU_DATA_W-1:0] result,
    output logic                  err
);

    logic signed [ALU_DATA_W-1:0] a_s;
    logic signed [ALU_DATA_W-1:0] b_s;
    logic        [4:0]            shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    // Opcode decode and evaluation; shifts only use the low five bits of b.
    always_comb begin
        result = '0;
        err    = (op > ALU_OP_MAX);
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(ALU_DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: result = {{(ALU_DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = a_s >>> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. The winner's
// result is captured into a one-entry output register tagged with the
// requester ID; the register accepts a new operation whenever it is empty
// or being drained in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_err
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              out_free;
    logic              accept;
    logic              accept_id;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_err;

    assign resp_valid = (state == ARB_FULL);
    assign out_free   = !resp_valid || resp_ready;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = grant0 && out_free;
    assign req1_ready = grant1 && out_free;
    assign accept     = req0_ready || req1_ready;
    assign accept_id  = req1_ready;

    assign alu_a  = grant1 ? req1_a  : req0_a;
    assign alu_b  = grant1 ? req1_b  : req0_b;
    assign alu_op = grant1 ? req1_op : req0_op;

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .err    (alu_err)
    );

    // Output-register occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_EMPTY;
        else     state <= state_nxt;
    end

    // Fill on acceptance; drain only when the consumer takes the result
    // and nothing new arrives behind it.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_EMPTY: if (accept) state_nxt = ARB_FULL;
            ARB_FULL:  if (resp_ready && !accept) state_nxt = ARB_EMPTY;
            default:   state_nxt = ARB_EMPTY;
        endcase
    end

    // Result payload; only reloaded on acceptance so it holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            resp_id     <= accept_id;
            resp_result <= alu_result;
            resp_err    <= alu_err;
        end
    end

    // Round-robin history; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= accept_id;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model of the arbiter and its result register.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {err, result}.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        return {(op > 4'd9), r};
    endfunction

    // Transaction-level model: who may go, what the register holds.
    logic        m_full, m_id, m_err, m_last;
    logic [31:0] m_result;
    int          wait0, wait1;

    function automatic int winner(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = 1'b0; m_id = 1'b0; m_result = 32'd0; m_err = 1'b0; m_last = 1'b1;
            wait0 = 0; wait1 = 0;
        end else begin
            int w;
            logic [32:0] r;
            w = (!m_full || resp_ready) ? winner(req0_valid, req1_valid, m_last) : -1;
            wait0 = (req0_valid && w != 0) ? wait0 + ((w == 1) ? 1 : 0) : 0;
            wait1 = (req1_valid && w != 1) ? wait1 + ((w == 0) ? 1 : 0) : 0;
            if (w == 0 || w == 1) begin
                r = (w == 0) ? ref_alu(req0_a, req0_b, req0_op) : ref_alu(req1_a, req1_b, req1_op);
                m_full = 1'b1; m_id = (w == 1); m_err = r[32]; m_result = r[31:0];
                m_last = (w == 1);
            end else if (m_full && resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (!rst) begin
            int w;
            w = (!m_full || resp_ready) ? winner(req0_valid, req1_valid, m_last) : -1;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_full});
            if (m_full) begin
                chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
                chk("resp_result", resp_result, m_result);
                chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
            end
            chk("starve0", {31'd0, wait0 <= 1}, 32'd1);
            chk("starve1", {31'd0, wait1 <= 1}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] exp, input string name);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        step();
        chk(name, resp_result, exp);
        req0_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        logic a0, a1;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;
        #1;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_id", {31'd0, resp_id}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        step();
        rst = 1'b0;

        // Single request, no contention.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
        #1 chk("single_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("single_valid", {31'd0, resp_valid}, 32'd1);
        chk("single_id", {31'd0, resp_id}, 32'd0);
        chk("single_result", resp_result, 32'd12);
        chk("single_err", {31'd0, resp_err}, 32'd0);
        step();

        // Tie: grants alternate starting with requester 0.
        pulse_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'd1;
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 4'd9;
        #1;
        chk("tie_first_r0", {31'd0, req0_ready}, 32'd1);
        chk("tie_first_r1", {31'd0, req1_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tie_id", {31'd0, resp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("tie_result", resp_result, (k % 2 == 0) ? 32'd7 : 32'hF800_0000);
        end

        // Backpressure: stall three cycles, then accept with no bubble.
        pulse_reset();
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'd4;
        step();
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_r0", {31'd0, req0_ready}, 32'd0);
            chk("bp_r1", {31'd0, req1_ready}, 32'd0);
            chk("bp_hold", resp_result, 32'd3);
            step();
        end
        resp_ready = 1'b1;
        #1 chk("bp_resume_r1", {31'd0, req1_ready}, 32'd1);
        step();
        chk("bp_resume_id", {31'd0, resp_id}, 32'd1);
        chk("bp_resume_result", resp_result, 32'h0000_00FF);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Illegal opcode.
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'd12;
        step();
        req1_valid = 1'b0;
        chk("illegal_id", {31'd0, resp_id}, 32'd1);
        chk("illegal_err", {31'd0, resp_err}, 32'd1);
        chk("illegal_result", resp_result, 32'd0);

        // Edge operations.
        op0(32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, "slt_neg");
        op0(32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0, "sltu_big");
        op0(32'd1, 32'd33, 4'd7, 32'd2, "sll_wrap_shamt");
        op0(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, "add_wrap");
        step();

        // Asynchronous reset while full and stalled.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'd0;
        step();
        req0_valid = 1'b0;
        chk("stall_full", {31'd0, resp_valid}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        chk("post_rst_r0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_r1", {31'd0, req1_ready}, 32'd0);
        step();

        // Randomized traffic; requesters hold each operation until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            step();
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = rnd_val(); req0_b = rnd_val(); req0_op = rnd_op();
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = rnd_val(); req1_b = rnd_val(); req1_op = rnd_op();
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
